simple_loop_main: RTL and testbench
===================================

Name: simple_loop_main

Overview:
- Sequential fixed-trip-count accumulation loop, the compiled form of a simple counted loop.
- On `go` it latches input `n`. It then runs TRIP iterations, one per clock, computing acc = acc + n + i (i = 0..TRIP-1, modulo 2^WIDTH).
- It then presents the final accumulator on `result` with a one-cycle `result_valid` pulse.
- Standalone top-level compute block driven by a simple go/valid handshake.

Parameters:
- WIDTH, 10, data width of n, accumulator and result; all arithmetic is modulo 2^WIDTH.
- TRIP, 16, number of loop iterations; the iteration counter is clog2(TRIP) bits wide, minimum 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous active-high.
- n  input  WIDTH  loop operand; sampled only at the start edge.
- go  input  1  start request; level-sensitive, sampled only in IDLE.
- result  output  WIDTH  last computed loop result; registered.
- result_valid  output  1  one-cycle pulse marking a new `result`; registered.

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state = IDLE, acc = 0, i = 0, n_reg = 0.
  - result = 0, result_valid = 0.
  - Reset mid-loop aborts the computation; no valid pulse is produced for it.
- Two-state FSM: IDLE, LOOP.
- IDLE:
  - If go=1 at an edge: n_reg <= n, acc <= 0, i <= 0, state <= LOOP.
  - If go=0: state is held.
- LOOP, every edge:
  - acc <= acc + n_reg + zero-extended i, truncated to WIDTH; i <= i + 1.
  - When i == TRIP-1: result <= acc + n_reg + i (truncated), result_valid <= 1, state <= IDLE.
- result_valid:
  - Default 0 on every edge except the final-iteration edge, so it is exactly one cycle wide.
  - result holds its value until the next completion or reset.
- Latency:
  - If go is sampled at edge k, result_valid is high in the cycle following edge k+TRIP (16 cycles for the default).
  - Closed form: result = (TRIP*n + TRIP*(TRIP-1)/2) mod 2^WIDTH, i.e. 16n+120 mod 1024 by default.
- go held high continuously:
  - The block returns to IDLE on the completion edge and restarts at the next edge.
  - Back-to-back period is TRIP+1 cycles, with one valid pulse per run.
- go during LOOP is ignored; no queuing.
- Changes to n during LOOP have no effect (n_reg is used).
- go asserted in the same cycle as rst: reset wins; the start is taken at the first edge with rst=0 and go=1.
- No combinational path from inputs to outputs.

Test Plan:
- rst=1 for 2 cycles, go=1, n=900 held -> result=0, result_valid=0 during reset. The first valid pulse arrives 16 cycles after the first start edge with result=184, then repeats every 17 cycles with result=184.
- n=0, single go pulse -> one valid pulse after 16 cycles with result=120; result_valid stays 0 afterwards and result holds 120.
- n=1023 -> result=104 (wrap-around); n=1 -> result=136.
- Start with n=5, change n to 700 and toggle go during LOOP -> result=200, only one valid pulse, no restart until back in IDLE.
- Assert rst at iteration 8 of a run with n=900 -> no valid pulse, result=0. After deassertion with go=1, a fresh run completes 16 cycles later with 184.
- go=0 after reset for 50 cycles -> result_valid never asserts and result stays 0.

Source files
------------

// File: rtl/simple_loop_main.sv
// Fixed-trip-count accumulation loop: on go, latch n and run TRIP iterations of
// acc = acc + n + i, then present the final sum with a one-cycle result_valid pulse.
module simple_loop_main #(
   parameter int WIDTH = 10,
   parameter int TRIP  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] n,
   input  logic             go,
   output logic [WIDTH-1:0] result,
   output logic             result_valid
);

   localparam int CNT_W = (TRIP > 1) ? $clog2(TRIP) : 1;
   localparam logic [CNT_W-1:0] LAST_I = CNT_W'(TRIP - 1);

   // Handshake: go is a level request sampled only while IDLE; result_valid is a
   // one-cycle pulse, and result holds its value until the next completion or reset.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOOP = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   i_q, i_d;
   logic [WIDTH-1:0]   n_reg_q, n_reg_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               result_valid_q, result_valid_d;
   logic [WIDTH-1:0]   iter_sum;

   assign iter_sum = acc_q + n_reg_q + WIDTH'(i_q);

   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      i_d            = i_q;
      n_reg_d        = n_reg_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               n_reg_d = n;
               acc_d   = '0;
               i_d     = '0;
               state_d = ST_LOOP;
            end
         end
         ST_LOOP: begin
            acc_d = iter_sum;
            i_d   = i_q + CNT_W'(1);
            if (i_q == LAST_I) begin
               result_d       = iter_sum;
               result_valid_d = 1'b1;
               state_d        = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         acc_q          <= '0;
         i_q            <= '0;
         n_reg_q        <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         i_q            <= i_d;
         n_reg_q        <= n_reg_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;

endmodule

// File: tb/tb_simple_loop_main.sv
// Directed bench for simple_loop_main: hand-computed results (16n+120 mod 1024),
// latency, back-to-back period, go/n changes mid-loop and reset abort.
module tb_simple_loop_main;

   localparam int WIDTH = 10;
   localparam int TRIP  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] n;
   logic             go;
   logic [WIDTH-1:0] result;
   logic             result_valid;

   int errors = 0;
   int checks = 0;

   simple_loop_main #(.WIDTH(WIDTH), .TRIP(TRIP)) dut (
      .clk          (clk),
      .rst          (rst),
      .n            (n),
      .go           (go),
      .result       (result),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until result_valid is seen; returns budget+1 on timeout.
   task automatic wait_valid(input int budget, output int cnt);
      cnt = budget + 1;
      for (int k = 1; k <= budget; k++) begin
         tick();
         if (result_valid) begin
            cnt = k;
            break;
         end
      end
   endtask

   task automatic run_one(input logic [WIDTH-1:0] nv, input logic [WIDTH-1:0] exp, input string tag);
      int cnt;
      n  = nv;
      go = 1'b1;
      tick();
      go = 1'b0;
      wait_valid(40, cnt);
      check({tag, "_latency"}, cnt, 16);
      check({tag, "_result"}, result, exp);
   endtask

   initial begin
      int cnt;
      int pulses;
      rst = 1'b1;
      go  = 1'b1;
      n   = 10'd900;

      // Reset with go held: outputs stay cleared, reset wins over go.
      tick();
      check("rst_result_0", result, 0);
      check("rst_valid_0", result_valid, 0);
      tick();
      check("rst_result_1", result, 0);
      check("rst_valid_1", result_valid, 0);
      rst = 1'b0;
      tick();  // start edge
      wait_valid(40, cnt);
      check("b2b_first_latency", cnt, 16);
      check("b2b_first_result", result, 184);
      wait_valid(40, cnt);
      check("b2b_period_1", cnt, 17);
      check("b2b_result_1", result, 184);
      wait_valid(40, cnt);
      check("b2b_period_2", cnt, 17);
      check("b2b_result_2", result, 184);
      go = 1'b0;

      // Single pulse with n=0, then quiet with result held.
      run_one(10'd0, 10'd120, "n0");
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (result_valid) pulses++;
      end
      check("n0_no_extra_pulse", pulses, 0);
      check("n0_result_held", result, 120);

      run_one(10'd1023, 10'd104, "n1023_wrap");
      run_one(10'd1, 10'd136, "n1");

      // n and go changes during LOOP are ignored.
      n  = 10'd5;
      go = 1'b1;
      tick();
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         n  = 10'd700;
         go = (k % 2 == 0);
         tick();
         if (result_valid) pulses++;
      end
      go = 1'b0;
      wait_valid(40, cnt);
      check("midloop_latency", cnt + 6, 16);
      check("midloop_result", result, 200);
      for (int k = 0; k < 20; k++) begin
         tick();
         if (result_valid) pulses++;
      end
      check("midloop_single_pulse", pulses, 0);
      check("midloop_result_held", result, 200);

      // Reset at iteration 8 aborts the run.
      n  = 10'd900;
      go = 1'b1;
      tick();
      go = 1'b0;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (result_valid) pulses++;
      end
      rst = 1'b1;
      go  = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_result", result, 0);
      check("abort_valid", result_valid, 0);
      check("abort_no_pulse_before", pulses, 0);
      tick();  // fresh start edge
      go = 1'b0;
      wait_valid(40, cnt);
      check("after_abort_latency", cnt, 16);
      check("after_abort_result", result, 184);

      // Idle after reset with go low: nothing happens.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (result_valid) pulses++;
      end
      check("idle_no_pulse", pulses, 0);
      check("idle_result_zero", result, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
